regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the next-generation RISC datapath. It replaces the fixed sixteen 32-bit register instances and one-hot enables with a generic NREGS x DATA_W array. It has two read ports and a direct write port, and it zeroes register 0 on port A in base-address mode. It adds a per-register busy scoreboard with issue/writeback handshakes, so multi-cycle units (mul/div, memory) can hold a destination register and write back later.

Parameters:
DATA_W, 32, register width in bits
NREGS, 16, number of registers (power of two, >= 2)
AW, $clog2(NREGS), register address width (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
clr  in  1  synchronous active-high reset
ra_addr  in  AW  read port A address
rb_addr  in  AW  read port B address
ba_mode  in  1  base-address mode; port A reads of reg 0 return 0
ra_data  out  DATA_W  port A read data (combinational)
rb_data  out  DATA_W  port B read data (combinational)
ra_busy  out  1  register at ra_addr is reserved
rb_busy  out  1  register at rb_addr is reserved
wr_en  in  1  direct single-cycle write request
wr_addr  in  AW  direct write address
wr_data  in  DATA_W  direct write data
iss_valid  in  1  request to reserve destination iss_addr
iss_addr  in  AW  destination register to reserve
iss_ready  out  1  reservation accepted this cycle
wb_valid  in  1  multi-cycle unit writeback request
wb_addr  in  AW  writeback destination
wb_data  in  DATA_W  writeback data
wb_ready  out  1  writeback accepted this cycle
busy  out  NREGS  scoreboard bit vector
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (clr=1 at rising edge): all registers 0, busy=0, err=0. clr overrides every same-cycle request; nothing in flight survives. Outputs after reset: ra_data/rb_data=0, ra_busy/rb_busy=0, busy=0, err=0, iss_ready=1 when iss_valid=1, wb_ready=1 unless wr_en=1.
- Reads are combinational.
- Read bypass: if an accepted write (direct or writeback) targets the read address in the same cycle, the read returns the incoming data.
- Port A zero rule: ba_mode=1 and ra_addr=0 returns 0, overriding the bypass. Port B is never masked.
- Write ports: direct write and writeback share one physical write port.
- Direct write has priority over writeback.
- wb_ready = wb_valid & ~wr_en. A stalled writeback must hold wb_valid/wb_addr/wb_data stable until accepted.
- Direct write rules:
  - Direct write to a reg with busy=0: written at the edge.
  - Direct write to a reg with busy=1: suppressed, err set.
- Writeback rules:
  - Accepted writeback writes wb_data and clears busy[wb_addr].
  - Accepted writeback to a non-busy reg: data still written, err set.
- Issue rules:
  - iss_ready = iss_valid & ~busy[iss_addr] & ~(wr_en & wr_addr==iss_addr).
  - On acceptance, busy[iss_addr] is set at the edge.
  - Issue to a reg that is busy, or that is the target of the same-cycle direct write, is refused with no state change. Refusal is not an error; the requester retries.
- Simultaneous writeback clearing reg k and issue to reg k:
  - iss_ready is computed from the pre-edge busy bit, so the issue is refused while busy[k]=1.
  - The writeback clears busy[k]. A retry next cycle is accepted.
- ra_busy/rb_busy reflect pre-edge busy bits, before same-cycle updates.
- err: sticky; cleared only by clr.
- All accepted actions take effect in one cycle; no internal pipeline.

Decomposition:
- Shared package rf_pkg:
  - DATA_W default
  - NREGS default
  - function clog2
  - localparam REG0 = 0
- Sub-module scoreboard_bits: NREGS-bit busy vector with set/clear/error logic, instantiated once.
- Storage array and bypass/zero muxing stay in the top level.

Test Plan:
- Reset + basic write/read: clr, then wr_en addr 5 data 0xDEADBEEF; next cycle ra_addr=5 -> ra_data=0xDEADBEEF, busy=0, err=0.
- Bypass and zero rule: wr_en addr 0 data 0x1234 with ra_addr=0, rb_addr=0, ba_mode=1 -> ra_data=0, rb_data=0x1234 same cycle. ba_mode=0 next cycle -> ra_data=0x1234.
- Scoreboard round trip:
  - Issue addr 3 -> iss_ready=1, busy[3]=1 next cycle.
  - Re-issue addr 3 -> iss_ready=0.
  - wb addr 3 data 0xCAFE0001 -> wb_ready=1, busy[3]=0, reg3=0xCAFE0001.
  - Retry issue -> accepted.
- Port contention: wr_en addr 2 data 7 with wb_valid addr 4 (busy) data 9 -> wb_ready=0, reg2=7. Next cycle wb accepted, reg4=9, busy[4]=0.
- Protocol errors:
  - Direct write to busy reg 6 -> reg6 unchanged, err=1.
  - clr -> err=0.
  - Writeback to non-busy reg 8 -> reg8 written, err=1.
- Reset mid-operation: busy=0x00F0, clr with wr_en and iss_valid asserted -> busy=0, all registers 0, no write or reservation performed.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the register file and its busy scoreboard.
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 16;
    localparam int REG0       = 0;

    // Elaboration-time ceiling log2; returns 1 for n <= 2 so address ports stay non-empty.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scoreboard_bits.sv
// Per-register busy bits with issue/writeback handshakes and a sticky protocol-error flag.
module scoreboard_bits
    import rf_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    localparam int AW   = clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             wb_accept,
    input  logic [AW-1:0]    wb_addr,
    output logic [NREGS-1:0] busy,
    output logic             iss_ready,
    output logic             err
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic             err_reg;
    logic             err_next;

    // A same-cycle direct write to the destination would race the reservation, so refuse it.
    assign iss_ready = iss_valid & ~busy_reg[iss_addr] & ~(wr_en && (wr_addr == iss_addr));

    // A fresh reservation wins over a stray writeback clearing the same bit.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (wb_accept && (wb_addr == AW'(gi))) begin
                    busy_next[gi] = 1'b0;
                end
                if (iss_ready && (iss_addr == AW'(gi))) begin
                    busy_next[gi] = 1'b1;
                end
            end
        end
    endgenerate

    assign err_next = err_reg
                    | (wr_en & busy_reg[wr_addr])
                    | (wb_accept & ~busy_reg[wb_addr]);

    always_ff @(posedge clk) begin
        if (clr) begin
            busy_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            err_reg  <= err_next;
        end
    end

    assign busy = busy_reg;
    assign err  = err_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// NREGS x DATA_W register file: two combinational read ports with write bypass,
// one shared write port (direct write over writeback), and a busy scoreboard.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    localparam int AW    = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    input  logic              ba_mode,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    output logic [NREGS-1:0]  busy,
    output logic              err
);

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic              wr_accept;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;

    scoreboard_bits #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .clr       (clr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wb_accept (wb_ready),
        .wb_addr   (wb_addr),
        .busy      (busy),
        .iss_ready (iss_ready),
        .err       (err)
    );

    // A direct write claims the port even when suppressed, so the writeback stalls regardless.
    assign wb_ready  = wb_valid & ~wr_en;
    assign wr_accept = wr_en & ~busy[wr_addr];
    assign we        = wr_accept | wb_ready;
    assign waddr     = wr_en ? wr_addr : wb_addr;
    assign wdata     = wr_en ? wr_data : wb_data;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we) begin
            regs_reg[waddr] <= wdata;
        end
    end

    // Zero masking on port A is applied last so it beats the bypass.
    always_comb begin
        ra_data = regs_reg[ra_addr];
        if (we && (waddr == ra_addr)) begin
            ra_data = wdata;
        end
        if (ba_mode && (ra_addr == AW'(REG0))) begin
            ra_data = '0;
        end
    end

    always_comb begin
        rb_data = regs_reg[rb_addr];
        if (we && (waddr == rb_addr)) begin
            rb_data = wdata;
        end
    end

    assign ra_busy = busy[ra_addr];
    assign rb_busy = busy[rb_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic        clk;
    logic        clr;
    logic [3:0]  ra_addr, rb_addr;
    logic        ba_mode;
    logic [31:0] ra_data, rb_data;
    logic        ra_busy, rb_busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_valid;
    logic [3:0]  iss_addr;
    logic        iss_ready;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic [15:0] busy;
    logic        err;

    regfile_scoreboard #(.DATA_W(32), .NREGS(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .ba_mode   (ba_mode),
        .ra_data   (ra_data),
        .rb_data   (rb_data),
        .ra_busy   (ra_busy),
        .rb_busy   (rb_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        clr;
        logic [3:0]  ra, rb;
        logic        ba;
        logic        wr_en;
        logic [3:0]  wr_a;
        logic [31:0] wr_d;
        logic        iss_v;
        logic [3:0]  iss_a;
        logic        wb_v;
        logic [3:0]  wb_a;
        logic [31:0] wb_d;
        logic [31:0] e_ra, e_rb;
        logic        e_rab, e_rbb, e_iss, e_wb;
        logic [15:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_miscompares;
    int   wait_cycles;
    bit   wb_seen;

    task automatic add(input string name, input logic c, input logic [3:0] ra, input logic [3:0] rb,
                       input logic ba, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [3:0] ia, input logic bv, input logic [3:0] ba_,
                       input logic [31:0] bd, input logic [31:0] era, input logic [31:0] erb,
                       input logic erab, input logic erbb, input logic eiss, input logic ewb,
                       input logic [15:0] ebusy, input logic eerr);
        vec_t v;
        v.name = name; v.clr = c; v.ra = ra; v.rb = rb; v.ba = ba;
        v.wr_en = we; v.wr_a = wa; v.wr_d = wd; v.iss_v = iv; v.iss_a = ia;
        v.wb_v = bv; v.wb_a = ba_; v.wb_d = bd;
        v.e_ra = era; v.e_rb = erb; v.e_rab = erab; v.e_rbb = erbb;
        v.e_iss = eiss; v.e_wb = ewb; v.e_busy = ebusy; v.e_err = eerr;
        vecs.push_back(v);
    endtask

    initial begin
        n_applied = 0;
        n_miscompares = 0;
        clr = 1'b1; ra_addr = '0; rb_addr = '0; ba_mode = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_addr = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;

        //   name          clr ra rb ba we wa wd            iv ia bv ba bd            e_ra          e_rb          rab rbb iss wb busy     err
        add("rst_hold",    1, 0, 0, 0, 0, 0, 0,            1, 1, 1, 2, 32'h55,       0,            0,            0, 0, 1, 1, 16'h0000, 0);
        add("rst_state",   0, 2, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,            0,            0, 0, 0, 0, 16'h0000, 0);
        add("wr5_byp",     0, 5, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,            32'hDEADBEEF, 0,            0, 0, 0, 0, 16'h0000, 0);
        add("rd5",         0, 5, 5, 1, 0, 0, 0,            0, 0, 0, 0, 0,            32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 16'h0000, 0);
        add("zero_byp",    0, 0, 0, 1, 1, 0, 32'h1234,     0, 0, 0, 0, 0,            0,            32'h1234,     0, 0, 0, 0, 16'h0000, 0);
        add("ba_off",      0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            32'h1234,     32'h1234,     0, 0, 0, 0, 16'h0000, 0);
        add("ba_on",       0, 0, 5, 1, 0, 0, 0,            0, 0, 0, 0, 0,            0,            32'hDEADBEEF, 0, 0, 0, 0, 16'h0000, 0);
        add("iss3",        0, 3, 3, 0, 0, 0, 0,            1, 3, 0, 0, 0,            0,            0,            0, 0, 1, 0, 16'h0000, 0);
        add("reiss3",      0, 3, 5, 0, 0, 0, 0,            1, 3, 0, 0, 0,            0,            32'hDEADBEEF, 1, 0, 0, 0, 16'h0008, 0);
        add("wb3_iss3",    0, 3, 0, 0, 0, 0, 0,            1, 3, 1, 3, 32'hCAFE0001, 32'hCAFE0001, 32'h1234,     1, 0, 0, 1, 16'h0008, 0);
        add("retry3",      0, 3, 0, 0, 0, 0, 0,            1, 3, 0, 0, 0,            32'hCAFE0001, 32'h1234,     0, 0, 1, 0, 16'h0000, 0);
        add("iss4",        0, 0, 4, 0, 0, 0, 0,            1, 4, 0, 0, 0,            32'h1234,     0,            0, 0, 1, 0, 16'h0008, 0);
        add("iss_wrconf",  0, 2, 3, 0, 1, 2, 32'h11,       1, 2, 0, 0, 0,            32'h11,       32'hCAFE0001, 0, 1, 0, 0, 16'h0018, 0);
        add("contend",     0, 2, 4, 0, 1, 2, 32'h7,        0, 0, 1, 4, 32'h9,        32'h7,        0,            0, 1, 0, 0, 16'h0018, 0);
        add("wb4",         0, 2, 4, 0, 0, 0, 0,            0, 0, 1, 4, 32'h9,        32'h7,        32'h9,        0, 1, 0, 1, 16'h0018, 0);
        add("chk4",        0, 4, 3, 0, 0, 0, 0,            0, 0, 0, 0, 0,            32'h9,        32'hCAFE0001, 0, 1, 0, 0, 16'h0008, 0);
        add("iss6",        0, 6, 6, 0, 0, 0, 0,            1, 6, 0, 0, 0,            0,            0,            0, 0, 1, 0, 16'h0008, 0);
        add("wr_busy6",    0, 6, 6, 0, 1, 6, 32'hBAD,      0, 0, 0, 0, 0,            0,            0,            1, 1, 0, 0, 16'h0048, 0);
        add("err_sticky",  0, 6, 2, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,            32'h7,        1, 0, 0, 0, 16'h0048, 1);
        add("clr_err",     1, 6, 2, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,            32'h7,        1, 0, 0, 0, 16'h0048, 1);
        add("post_clr",    0, 3, 4, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,            0,            0, 0, 0, 0, 16'h0000, 0);
        add("wb_nonbusy8", 0, 8, 2, 0, 0, 0, 0,            0, 0, 1, 8, 32'h88,       32'h88,       0,            0, 0, 0, 1, 16'h0000, 0);
        add("chk8",        0, 8, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            32'h88,       0,            0, 0, 0, 0, 16'h0000, 1);
        add("clr_err2",    1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,            0,            0, 0, 0, 0, 16'h0000, 1);
        add("res4",        0, 8, 0, 0, 0, 0, 0,            1, 4, 0, 0, 0,            0,            0,            0, 0, 1, 0, 16'h0000, 0);
        add("res5",        0, 0, 4, 0, 0, 0, 0,            1, 5, 0, 0, 0,            0,            0,            0, 1, 1, 0, 16'h0010, 0);
        add("res6",        0, 0, 5, 0, 0, 0, 0,            1, 6, 0, 0, 0,            0,            0,            0, 1, 1, 0, 16'h0030, 0);
        add("res7_wr1",    0, 1, 6, 0, 1, 1, 32'h77,       1, 7, 0, 0, 0,            32'h77,       0,            0, 1, 1, 0, 16'h0070, 0);
        add("clr_mid",     1, 1, 1, 0, 1, 9, 32'h99,       1, 2, 0, 0, 0,            32'h77,       32'h77,       0, 0, 1, 0, 16'h00F0, 0);
        add("after_clr",   0, 9, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,            0,            0, 0, 0, 0, 16'h0000, 0);
        add("after_clr2",  0, 2, 5, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,            0,            0, 0, 0, 0, 16'h0000, 0);

        repeat (2) @(posedge clk);

        @(negedge clk);
        #1;
        if (ra_data !== 32'h0 || rb_data !== 32'h0 || ra_busy !== 1'b0 || rb_busy !== 1'b0 ||
            busy !== 16'h0000 || err !== 1'b0 || iss_ready !== 1'b0 || wb_ready !== 1'b0) begin
            n_miscompares++;
            $display("FAIL reset_state: ra=%h rb=%h rab=%b rbb=%b iss=%b wb=%b busy=%h err=%b",
                     ra_data, rb_data, ra_busy, rb_busy, iss_ready, wb_ready, busy, err);
        end else begin
            $display("reset_state ok: ra=%h rb=%h busy=%h err=%b", ra_data, rb_data, busy, err);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clr = vecs[i].clr; ra_addr = vecs[i].ra; rb_addr = vecs[i].rb; ba_mode = vecs[i].ba;
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_a; wr_data = vecs[i].wr_d;
            iss_valid = vecs[i].iss_v; iss_addr = vecs[i].iss_a;
            wb_valid = vecs[i].wb_v; wb_addr = vecs[i].wb_a; wb_data = vecs[i].wb_d;
            #1;
            n_applied++;
            if (ra_data !== vecs[i].e_ra || rb_data !== vecs[i].e_rb ||
                ra_busy !== vecs[i].e_rab || rb_busy !== vecs[i].e_rbb ||
                iss_ready !== vecs[i].e_iss || wb_ready !== vecs[i].e_wb ||
                busy !== vecs[i].e_busy || err !== vecs[i].e_err) begin
                n_miscompares++;
                $display("FAIL vec %0d %s: got ra=%h rb=%h rab=%b rbb=%b iss=%b wb=%b busy=%h err=%b, want ra=%h rb=%h rab=%b rbb=%b iss=%b wb=%b busy=%h err=%b",
                         i, vecs[i].name, ra_data, rb_data, ra_busy, rb_busy, iss_ready, wb_ready, busy, err,
                         vecs[i].e_ra, vecs[i].e_rb, vecs[i].e_rab, vecs[i].e_rbb, vecs[i].e_iss,
                         vecs[i].e_wb, vecs[i].e_busy, vecs[i].e_err);
            end else begin
                $display("vec %0d %s ok: ra=%h rb=%h busy=%h err=%b", i, vecs[i].name, ra_data, rb_data, busy, err);
            end
        end

        @(negedge clk);
        clr = 1'b0; wr_en = 1'b0; wb_valid = 1'b0; ba_mode = 1'b0;
        iss_valid = 1'b1; iss_addr = 4'd10;
        @(negedge clk);
        iss_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 4'd10; wb_data = 32'hA5A5_0010;
        ra_addr = 4'd10; rb_addr = 4'd10;
        wait_cycles = 0;
        wb_seen = 1'b0;
        #1;
        while (!wb_seen && wait_cycles < 8) begin
            if (wb_ready === 1'b1) begin
                wb_seen = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                wait_cycles++;
            end
        end
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        if (!wb_seen || busy[10] !== 1'b0 || err !== 1'b0 || ra_data !== 32'hA5A5_0010) begin
            n_miscompares++;
            $display("FAIL wb_wait: seen=%b cycles=%0d busy=%h err=%b ra=%h", wb_seen, wait_cycles, busy, err, ra_data);
        end else begin
            $display("wb_wait ok: cycles=%0d busy=%h err=%b ra=%h", wait_cycles, busy, err, ra_data);
        end

        @(negedge clk);
        clr = 1'b0; wr_en = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
